// File: rtl/vsi_mem_pkg.sv
// vsi_mem_pkg: shared widths and the byte-lane merge helper for the vsi memory responder.
package vsi_mem_pkg;
   localparam int WORD_W   = 128;
   localparam int STRB_W   = 16;
   localparam int ADDR_W   = 32;
   localparam int BYTE_OFF = 4;

   function automatic logic [WORD_W-1:0] lane_merge(
      input logic [WORD_W-1:0] old_w,
      input logic [WORD_W-1:0] new_w,
      input logic [STRB_W-1:0] strb
   );
      logic [WORD_W-1:0] r;
      r = old_w;
      for (int i = 0; i < STRB_W; i++)
         if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/vsi_lat_pipe.sv
// vsi_lat_pipe: valid+data delay line of DEPTH stages with synchronous clear.
//   clk, rst          clock and synchronous active-high clear of every stage
//   in_valid/in_data  beat entering the line
//   out_valid/out_data beat leaving the line DEPTH cycles later (pass-through when DEPTH=0)
module vsi_lat_pipe #(
   parameter int DEPTH = 1,
   parameter int W     = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);
   if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
   end else begin : g_pipe
      logic [DEPTH-1:0]        valid_q, valid_d;
      logic [DEPTH-1:0][W-1:0] data_q, data_d;
      always_comb begin
         valid_d[0] = in_valid;
         data_d[0]  = in_data;
         for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end
      // Data is cleared too so the output stays zero after reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
      end
      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
   end
endmodule

// File: rtl/vsi_mem_responder.sv
// vsi_mem_responder: byte-strobed 128-bit word store answering vsi reads in order after READ_LAT cycles.
//   vsi_clk, vsi_reset            clock, synchronous active-high reset (storage is preserved)
//   vsi_raddr_valid, vsi_raddr    read request, accepted every cycle
//   vsi_rdata_valid, vsi_rdata    read beat, data zero when not valid
//   vsi_wx_valid, vsi_waddr, vsi_wdata, vsi_wstrobe  write beat, accepted every cycle
//   rd_count, wr_count            saturating accepted-beat counters
//   addr_err, err_clr             sticky out-of-range/misaligned flag and its clear
module vsi_mem_responder
   import vsi_mem_pkg::*;
#(
   parameter int               DEPTH_WORDS = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
   parameter int               READ_LAT    = 2
) (
   input  logic              vsi_clk,
   input  logic              vsi_reset,
   input  logic              vsi_raddr_valid,
   input  logic [ADDR_W-1:0] vsi_raddr,
   output logic              vsi_rdata_valid,
   output logic [WORD_W-1:0] vsi_rdata,
   input  logic              vsi_wx_valid,
   input  logic [ADDR_W-1:0] vsi_waddr,
   input  logic [WORD_W-1:0] vsi_wdata,
   input  logic [STRB_W-1:0] vsi_wstrobe,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count,
   output logic              addr_err,
   input  logic              err_clr
);
   localparam int IDX_W = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   // One extra bit so the limit itself cannot wrap for large stores.
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << BYTE_OFF;

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [ADDR_W-1:0] r_off, w_off;
   logic [IDX_W-1:0]  r_idx, w_idx;
   logic              r_ok, w_ok, bad, we;
   logic              rv_q, rv_d, err_q, err_d;
   logic [WORD_W-1:0] rd_q, rd_d, wr_word_d;
   logic [31:0]       rd_count_q, rd_count_d, wr_count_q, wr_count_d;

   always_comb begin
      r_off      = vsi_raddr - BASE_ADDR;
      w_off      = vsi_waddr - BASE_ADDR;
      r_ok       = {1'b0, r_off} < LIMIT;
      w_ok       = {1'b0, w_off} < LIMIT;
      r_idx      = r_off[BYTE_OFF +: IDX_W];
      w_idx      = w_off[BYTE_OFF +: IDX_W];
      rv_d       = vsi_raddr_valid;
      // Array read happens before this edge's write lands, so same-cycle read sees old data.
      rd_d       = (vsi_raddr_valid && r_ok) ? mem_q[r_idx] : '0;
      wr_word_d  = lane_merge(mem_q[w_idx], vsi_wdata, vsi_wstrobe);
      we         = vsi_wx_valid && w_ok && !vsi_reset;
      bad        = (vsi_raddr_valid && (!r_ok || vsi_raddr[BYTE_OFF-1:0] != '0)) ||
                   (vsi_wx_valid && (!w_ok || vsi_waddr[BYTE_OFF-1:0] != '0));
      err_d      = bad ? 1'b1 : err_clr ? 1'b0 : err_q;
      rd_count_d = rd_count_q + 32'(vsi_raddr_valid && rd_count_q != '1);
      wr_count_d = wr_count_q + 32'(vsi_wx_valid && wr_count_q != '1);
   end

   always_ff @(posedge vsi_clk) begin
      if (we) mem_q[w_idx] <= wr_word_d;
   end

   always_ff @(posedge vsi_clk) begin
      if (vsi_reset) begin
         rv_q       <= 1'b0;
         rd_q       <= '0;
         err_q      <= 1'b0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rv_q       <= rv_d;
         rd_q       <= rd_d;
         err_q      <= err_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   vsi_lat_pipe #(
      .DEPTH (READ_LAT - 1),
      .W     (WORD_W)
   ) u_pipe (
      .clk       (vsi_clk),
      .rst       (vsi_reset),
      .in_valid  (rv_q),
      .in_data   (rd_q),
      .out_valid (vsi_rdata_valid),
      .out_data  (vsi_rdata)
   );

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
   assign addr_err = err_q;
endmodule

// File: tb/tb_vsi_mem_responder.sv
// tb_vsi_mem_responder: randomized and directed checks of vsi_mem_responder against a queue-based model.
module tb_vsi_mem_responder;
   localparam int          DW   = 64;
   localparam int          RL   = 3;
   localparam logic [31:0] BASE = 32'h0;

   logic         clk;
   logic         rst;
   logic         rv, wv, clr;
   logic [31:0]  ra, wa;
   logic [127:0] wd;
   logic [15:0]  ws;
   logic         dv;
   logic [127:0] dd;
   logic [31:0]  rc, wc;
   logic         err;

   vsi_mem_responder #(
      .DEPTH_WORDS (DW),
      .BASE_ADDR   (BASE),
      .READ_LAT    (RL)
   ) dut (
      .vsi_clk         (clk),
      .vsi_reset       (rst),
      .vsi_raddr_valid (rv),
      .vsi_raddr       (ra),
      .vsi_rdata_valid (dv),
      .vsi_rdata       (dd),
      .vsi_wx_valid    (wv),
      .vsi_waddr       (wa),
      .vsi_wdata       (wd),
      .vsi_wstrobe     (ws),
      .rd_count        (rc),
      .wr_count        (wc),
      .addr_err        (err),
      .err_clr         (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [127:0] data;
   } beat_t;

   logic [127:0] mem_m [DW];
   beat_t        q_m [$];
   int           edge_n;
   logic [31:0]  rc_m, wc_m;
   logic         err_m;
   int           n_cmp, n_bad;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, obs, exp);
      end
   endtask

   function automatic logic in_rng(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return 64'(off) < 64'(DW * 16);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'(off >> 4);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return v == 32'hFFFF_FFFF ? v : v + 32'd1;
   endfunction

   task automatic cyc(input logic r_v, input logic [31:0] r_a, input logic w_v, input logic [31:0] w_a,
                      input logic [127:0] w_d, input logic [15:0] w_s, input logic c, input logic rs);
      logic         ev;
      logic [127:0] ed;
      beat_t        b;
      rv = r_v; ra = r_a; wv = w_v; wa = w_a; wd = w_d; ws = w_s; clr = c; rst = rs;
      @(posedge clk);
      edge_n++;
      if (rs) begin
         q_m.delete();
         rc_m  = 0;
         wc_m  = 0;
         err_m = 1'b0;
      end else begin
         if (r_v) begin
            b.due  = edge_n + RL - 1;
            b.data = in_rng(r_a) ? mem_m[idx_of(r_a)] : 128'h0;
            q_m.push_back(b);
            rc_m = sat_inc(rc_m);
         end
         if (w_v) begin
            if (in_rng(w_a))
               for (int i = 0; i < 16; i++)
                  if (w_s[i]) mem_m[idx_of(w_a)][8*i +: 8] = w_d[8*i +: 8];
            wc_m = sat_inc(wc_m);
         end
         if ((r_v && (!in_rng(r_a) || r_a[3:0] != 0)) || (w_v && (!in_rng(w_a) || w_a[3:0] != 0)))
            err_m = 1'b1;
         else if (c)
            err_m = 1'b0;
      end
      #1;
      ev = 1'b0;
      ed = '0;
      if (q_m.size() > 0 && q_m[0].due == edge_n) begin
         ev = 1'b1;
         ed = q_m.pop_front().data;
      end
      chk("rdata_valid", 128'(dv), 128'(ev));
      chk("rdata", dd, ed);
      chk("rd_count", 128'(rc), 128'(rc_m));
      chk("wr_count", 128'(wc), 128'(wc_m));
      chk("addr_err", 128'(err), 128'(err_m));
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rd(input logic [31:0] a);
      cyc(1, a, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
      cyc(0, 0, 1, a, d, s, 0, 0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; edge_n = 0;
      rc_m = 0; wc_m = 0; err_m = 0;
      rv = 0; ra = 0; wv = 0; wa = 0; wd = 0; ws = 0; clr = 0; rst = 1;
      for (int i = 0; i < DW; i++) mem_m[i] = '0;
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DW; i++)
         wr(BASE + 32'(i * 16), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      wr(BASE, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF);
      rd(BASE);
      idle(RL);
      chk("rd_count_one", 128'(rc), 128'd1);
      chk("wr_count_one", 128'(wc), 128'd1);
      wr(BASE, {16{8'hAA}}, 16'hFFFF);
      wr(BASE, {16{8'h55}}, 16'h00F0);
      rd(BASE);
      idle(RL);
      for (int i = 0; i < 8; i++) rd(BASE + 32'(i * 16));
      idle(RL);
      cyc(1, BASE + 32'h20, 1, BASE + 32'h20, {4{32'hDEAD_BEEF}}, 16'hFFFF, 0, 0);
      rd(BASE + 32'h20);
      idle(RL);
      cyc(1, BASE + 32'(DW * 16), 1, BASE + 32'h4, {4{32'h1234_5678}}, 16'h000F, 0, 0);
      idle(RL);
      chk("err_sticky", 128'(err), 128'd1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk("err_cleared", 128'(err), 128'd0);
      cyc(1, BASE + 32'h10, 0, 0, 0, 0, 1, 0);
      cyc(1, BASE + 32'(DW * 16 + 16), 0, 0, 0, 0, 1, 0);
      idle(2);
      rd(BASE + 32'h10);
      rd(BASE + 32'h20);
      cyc(1, BASE + 32'h30, 0, 0, 0, 0, 0, 1);
      idle(RL + 2);
      rd(BASE);
      rd(BASE + 32'h20);
      idle(RL);
      for (int n = 0; n < 2000; n++) begin
         logic [31:0] a_r, a_w;
         a_r = BASE + (32'($urandom_range(0, DW + 3)) << 4);
         a_w = BASE + (32'($urandom_range(0, DW + 3)) << 4);
         if ($urandom_range(0, 7) == 0) a_r[3:0] = 4'($urandom_range(1, 15));
         if ($urandom_range(0, 7) == 0) a_w[3:0] = 4'($urandom_range(1, 15));
         cyc(1'($urandom_range(0, 1)), a_r, 1'($urandom_range(0, 1)), a_w,
             {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
             $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
      end
      idle(RL + 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
